reset_sequencer: RTL and testbench
==================================

Name: reset_sequencer

Overview:
- Central reset controller for the C64 core.
- Collects all reset sources: power-up, FPGA button, software request and PLL lock loss.
- Holds every domain in reset for a programmable time, then releases NUM_DOMAINS domain resets one after another in a fixed order (memory, VIC, CIA/SID, CPU), spaced by a programmable gap.
- Reports the cause of the last reset and whether a sequence is in progress.

Parameters:
- NUM_DOMAINS, 4: number of sequenced active-low reset outputs; bit 0 is released first.
- HOLD_CYCLES, 5000000: cycles of stable PLL lock required before release starts (500 ms at 10 MHz).
- DEBOUNCE_CYCLES, 100000: consecutive equal synchronised button samples needed to accept a new level (10 ms).
- STAGE_GAP, 16: cycles between consecutive domain releases; minimum 1.

Ports:
- clk  in  1  10 MHz system clock.
- reset  in  1  asynchronous, active-low; forces the block into its reset state.
- fpga_but1  in  1  raw button, active-low, asynchronous.
- pll_locked  in  1  PLL lock indication, asynchronous.
- sw_reset_req  in  1  single-cycle, clk-synchronous software reset request.
- reset_n_out  out  NUM_DOMAINS  per-domain reset, active-low.
- busy  out  1  high from reset entry until all domains are released.
- cause  out  2  last reset cause: 00 power-on, 01 button, 10 software, 11 PLL lock loss.

Behaviour:
- Reset state (reset=0), all values held while reset is low:
  - reset_n_out=0 (all domains), busy=1, cause=00, state=HOLD.
  - All counters 0; both synchronisers 0; debounced button state = released.
- Synchronisers:
  - fpga_but1 and pll_locked each pass through a 2-FF synchroniser; all logic below uses the synchronised values.
- Debounce:
  - Debounced level changes only after DEBOUNCE_CYCLES consecutive synchronised samples differ from the current debounced level.
  - Any sample equal to the current level clears the debounce counter.
- Trigger, evaluated every cycle; any one of these raises it:
  - pll_locked_s=0 while state is RELEASE or RUN;
  - a debounced press edge, or the debounced button still held;
  - sw_reset_req=1.
- On a trigger, in the same clock edge:
  - reset_n_out becomes all 0 and busy becomes 1;
  - state goes to HOLD and hold_cnt clears;
  - cause updates, priority lock loss (11) > button (01) > software (10).
  - A held button re-triggers every cycle but sets cause=01 only once per press.
- HOLD:
  - hold_cnt increments on each cycle with pll_locked_s=1; it clears on any cycle with pll_locked_s=0.
  - pll_locked_s=0 in HOLD does not change cause.
  - When hold_cnt reaches HOLD_CYCLES-1 with lock present: go to RELEASE, stage=0, gap_cnt=0.
- RELEASE:
  - gap_cnt increments each cycle.
  - When gap_cnt = STAGE_GAP-1: reset_n_out[stage] goes to 1, stage increments, gap_cnt clears.
  - Release of the last bit moves to RUN and drops busy on the same edge.
  - Bits already released stay 1 until the next trigger.
- RUN:
  - Outputs stay constant; only a trigger leaves this state.
- Counter widths are sized with $clog2 of the parameters.
  - hold_cnt saturates; it never wraps.
  - sw_reset_req pulses in HOLD only restart the hold count.
- Async reset asserted mid-sequence returns everything to the reset state immediately, without waiting for clk.

Test Plan (HOLD_CYCLES=20, DEBOUNCE_CYCLES=4, STAGE_GAP=3, NUM_DOMAINS=4; edge 1 = first clk rise after reset deassert):
- Power-up with pll_locked=1 and button released:
  - reset_n_out bits 0..3 rise at edges 25, 28, 31 and 34 respectively.
  - busy falls at edge 34; cause=00.
- PLL lock drops for 5 cycles during HOLD:
  - hold_cnt restarts; every release time is delayed by (gap + 2 sync) cycles.
  - cause stays 00.
- In RUN, pll_locked falls:
  - reset_n_out=0000 and busy=1 by 3 edges after the fall (2 sync + 1); cause=11.
  - After relock, the sequence repeats with the same 3-cycle stage spacing.
- In RUN, button low for 3 cycles (glitch): no effect.
- In RUN, button low for 50 cycles:
  - Outputs are 0 from edge 2+4+1 after the press; cause=01.
  - First release occurs 20+3+1 edges after the debounced release is accepted.
- sw_reset_req pulse coinciding with a lock-loss trigger in RUN: cause=11, all domains reset.
- Async reset asserted mid-RELEASE with bits 0 and 1 high: immediately all outputs 0, busy=1, cause=00.

Source files
------------

// File: rtl/reset_sequencer.sv
// Central reset controller: merges power-up, button, software and PLL-lock-loss
// reset sources and releases the per-domain resets one after another.
module reset_sequencer #(
  parameter int NUM_DOMAINS     = 4,
  parameter int HOLD_CYCLES     = 5000000,
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int STAGE_GAP       = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   fpga_but1,
  input  logic                   pll_locked,
  input  logic                   sw_reset_req,
  output logic [NUM_DOMAINS-1:0] reset_n_out,
  output logic                   busy,
  output logic [1:0]             cause
);

  localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int DEB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int GAP_W  = (STAGE_GAP > 1) ? $clog2(STAGE_GAP) : 1;
  localparam int STG_W  = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

  localparam logic [HOLD_W-1:0] HOLD_LAST  = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [DEB_W-1:0]  DEB_LAST   = DEB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [GAP_W-1:0]  GAP_LAST   = GAP_W'(STAGE_GAP - 1);
  localparam logic [STG_W-1:0]  STAGE_LAST = STG_W'(NUM_DOMAINS - 1);

  localparam logic [1:0] CAUSE_POR = 2'b00;
  localparam logic [1:0] CAUSE_BTN = 2'b01;
  localparam logic [1:0] CAUSE_SW  = 2'b10;
  localparam logic [1:0] CAUSE_PLL = 2'b11;

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2
  } state_e;

  logic but_meta_q, but_s_q;
  logic pll_meta_q, pll_s_q;

  logic             btn_db_q, btn_db_d;
  logic             btn_prev_q;
  logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;

  state_e                 state_q, state_d;
  logic [HOLD_W-1:0]      hold_q, hold_d;
  logic [GAP_W-1:0]       gap_q, gap_d;
  logic [STG_W-1:0]       stage_q, stage_d;
  logic [NUM_DOMAINS-1:0] rst_out_q, rst_out_d;
  logic                   busy_q, busy_d;
  logic [1:0]             cause_q, cause_d;

  logic press_edge, btn_held, lock_loss, trigger;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      but_meta_q <= 1'b0;
      but_s_q    <= 1'b0;
      pll_meta_q <= 1'b0;
      pll_s_q    <= 1'b0;
    end else begin
      but_meta_q <= fpga_but1;
      but_s_q    <= but_meta_q;
      pll_meta_q <= pll_locked;
      pll_s_q    <= pll_meta_q;
    end
  end

  // Button is active-low: debounced level 1 means released.
  always_comb begin
    btn_db_d  = btn_db_q;
    deb_cnt_d = '0;
    if (but_s_q != btn_db_q) begin
      if (deb_cnt_q == DEB_LAST) begin
        btn_db_d = but_s_q;
      end else begin
        deb_cnt_d = deb_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      btn_db_q   <= 1'b1;
      btn_prev_q <= 1'b1;
      deb_cnt_q  <= '0;
    end else begin
      btn_db_q   <= btn_db_d;
      btn_prev_q <= btn_db_q;
      deb_cnt_q  <= deb_cnt_d;
    end
  end

  // "Held" looks at the delayed level so the edge after release still retriggers.
  assign press_edge = !btn_db_q && btn_prev_q;
  assign btn_held   = !btn_prev_q;
  assign lock_loss  = !pll_s_q && (state_q != ST_HOLD);
  assign trigger    = lock_loss || press_edge || btn_held || sw_reset_req;

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    gap_d     = gap_q;
    stage_d   = stage_q;
    rst_out_d = rst_out_q;
    busy_d    = busy_q;
    cause_d   = cause_q;
    if (trigger) begin
      state_d   = ST_HOLD;
      hold_d    = '0;
      gap_d     = '0;
      stage_d   = '0;
      rst_out_d = '0;
      busy_d    = 1'b1;
      if (lock_loss) begin
        cause_d = CAUSE_PLL;
      end else if (press_edge) begin
        cause_d = CAUSE_BTN;
      end else if (!btn_held) begin
        cause_d = CAUSE_SW;
      end
    end else begin
      case (state_q)
        ST_HOLD: begin
          if (!pll_s_q) begin
            hold_d = '0;
          end else if (hold_q == HOLD_LAST) begin
            state_d = ST_RELEASE;
            stage_d = '0;
            gap_d   = '0;
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end
        ST_RELEASE: begin
          if (gap_q == GAP_LAST) begin
            rst_out_d[stage_q] = 1'b1;
            gap_d              = '0;
            if (stage_q == STAGE_LAST) begin
              state_d = ST_RUN;
              busy_d  = 1'b0;
            end else begin
              stage_d = stage_q + 1'b1;
            end
          end else begin
            gap_d = gap_q + 1'b1;
          end
        end
        ST_RUN: begin
        end
        default: begin
          state_d = ST_HOLD;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_HOLD;
      hold_q    <= '0;
      gap_q     <= '0;
      stage_q   <= '0;
      rst_out_q <= '0;
      busy_q    <= 1'b1;
      cause_q   <= CAUSE_POR;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      gap_q     <= gap_d;
      stage_q   <= stage_d;
      rst_out_q <= rst_out_d;
      busy_q    <= busy_d;
      cause_q   <= cause_d;
    end
  end

  assign reset_n_out = rst_out_q;
  assign busy        = busy_q;
  assign cause       = cause_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed testbench for reset_sequencer with small timing parameters;
// expected edge numbers are hand-computed from the sequencing rules.
`timescale 1ns/1ps
module tb_reset_sequencer;

  localparam int ND = 4;

  logic          clk;
  logic          reset;
  logic          fpga_but1;
  logic          pll_locked;
  logic          sw_reset_req;
  logic [ND-1:0] reset_n_out;
  logic          busy;
  logic [1:0]    cause;

  int checks = 0;
  int errors = 0;
  int riseEdge [ND];
  int busyEdge;

  reset_sequencer #(
    .NUM_DOMAINS(ND),
    .HOLD_CYCLES(20),
    .DEBOUNCE_CYCLES(4),
    .STAGE_GAP(3)
  ) dut (
    .clk(clk),
    .reset(reset),
    .fpga_but1(fpga_but1),
    .pll_locked(pll_locked),
    .sw_reset_req(sw_reset_req),
    .reset_n_out(reset_n_out),
    .busy(busy),
    .cause(cause)
  );

  initial clk = 1'b0;
  always #50 clk = ~clk;

  task automatic checkOutput(input string tag, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic but, input logic pll, input logic sw);
    fpga_but1    = but;
    pll_locked   = pll;
    sw_reset_req = sw;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs until busy drops, recording the edge (1 = first edge of the call) at
  // which each domain first reads released. pll_locked is low for edges in
  // [dropFirst, dropLast] and high otherwise.
  task automatic watchRelease(input string tag, input int dropFirst, input int dropLast);
    int n;
    n = 0;
    for (int i = 0; i < ND; i++) riseEdge[i] = -1;
    busyEdge = -1;
    while (n < 200 && busyEdge < 0) begin
      pll_locked = (n + 1 >= dropFirst && n + 1 <= dropLast) ? 1'b0 : 1'b1;
      tick();
      n++;
      for (int i = 0; i < ND; i++)
        if (reset_n_out[i] && riseEdge[i] < 0) riseEdge[i] = n;
      if (!busy) busyEdge = n;
    end
    if (busyEdge < 0) checkOutput({tag, "_timeout"}, 0, 1);
  endtask

  task automatic checkRelease(input string tag, input int firstEdge);
    for (int i = 0; i < ND; i++)
      checkOutput($sformatf("%s_bit%0d", tag, i), riseEdge[i], firstEdge + 3 * i);
    checkOutput({tag, "_busy_fall"}, busyEdge, firstEdge + 9);
    checkOutput({tag, "_outs_final"}, reset_n_out, 4'hF);
  endtask

  initial begin
    int bad;
    int found;
    reset = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b0);
    repeat (3) tick();
    checkOutput("rst_outs", reset_n_out, 0);
    checkOutput("rst_busy", busy, 1);
    checkOutput("rst_cause", cause, 0);

    // Power-up: bits rise at edges 25, 28, 31, 34.
    @(negedge clk);
    reset = 1'b1;
    watchRelease("por", 0, -1);
    checkRelease("por", 25);
    checkOutput("por_cause", cause, 0);

    // Lock loss in RUN: outputs drop on the third edge after the fall.
    applyStimulus(1'b1, 1'b0, 1'b0);
    tick();
    tick();
    checkOutput("pll_still_run", reset_n_out, 4'hF);
    tick();
    checkOutput("pll_outs", reset_n_out, 0);
    checkOutput("pll_busy", busy, 1);
    checkOutput("pll_cause", cause, 3);
    watchRelease("relock", 0, -1);
    checkRelease("relock", 25);
    checkOutput("relock_cause", cause, 3);

    // Three-cycle button glitch must be filtered.
    bad = 0;
    applyStimulus(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 13; i++) begin
      if (i == 3) fpga_but1 = 1'b1;
      tick();
      if (reset_n_out != 4'hF) bad++;
    end
    checkOutput("glitch_stable", bad, 0);
    checkOutput("glitch_busy", busy, 0);
    checkOutput("glitch_cause", cause, 3);

    // Button held for 50 cycles: outputs drop at edge 7.
    applyStimulus(1'b0, 1'b1, 1'b0);
    repeat (6) tick();
    checkOutput("btn_before", reset_n_out, 4'hF);
    tick();
    checkOutput("btn_outs", reset_n_out, 0);
    checkOutput("btn_cause", cause, 1);
    bad = 0;
    for (int i = 0; i < 43; i++) begin
      tick();
      if (reset_n_out != 0 || !busy) bad++;
    end
    checkOutput("btn_held_low", bad, 0);
    // Released level accepted at edge 6, first release 24 edges later.
    fpga_but1 = 1'b1;
    watchRelease("btnrel", 0, -1);
    checkRelease("btnrel", 30);
    checkOutput("btnrel_cause", cause, 1);

    // Software request alone.
    applyStimulus(1'b1, 1'b1, 1'b1);
    tick();
    sw_reset_req = 1'b0;
    checkOutput("sw_outs", reset_n_out, 0);
    checkOutput("sw_busy", busy, 1);
    checkOutput("sw_cause", cause, 2);
    watchRelease("swrel", 0, -1);
    checkRelease("swrel", 23);

    // Software request on the same edge as a lock-loss trigger.
    applyStimulus(1'b1, 1'b0, 1'b0);
    tick();
    tick();
    sw_reset_req = 1'b1;
    tick();
    sw_reset_req = 1'b0;
    checkOutput("both_outs", reset_n_out, 0);
    checkOutput("both_cause", cause, 3);
    watchRelease("bothrel", 0, -1);
    checkRelease("bothrel", 25);

    // Async reset in the middle of RELEASE.
    applyStimulus(1'b1, 1'b1, 1'b1);
    tick();
    sw_reset_req = 1'b0;
    found = 0;
    for (int i = 0; i < 100 && found == 0; i++) begin
      tick();
      if (reset_n_out == 4'b0011) found = 1;
    end
    checkOutput("mid_found", found, 1);
    checkOutput("mid_cause_pre", cause, 2);
    #20;
    reset = 1'b0;
    #1;
    checkOutput("async_outs", reset_n_out, 0);
    checkOutput("async_busy", busy, 1);
    checkOutput("async_cause", cause, 0);
    repeat (2) tick();
    checkOutput("async_hold_outs", reset_n_out, 0);

    // Power-up with lock missing for edges 3..7 while in HOLD: 7 edges late.
    @(negedge clk);
    reset = 1'b1;
    watchRelease("holddrop", 3, 7);
    checkRelease("holddrop", 32);
    checkOutput("holddrop_cause", cause, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
